// File: rtl/sha_match_filter_if.sv
// sha_match_filter_if: digest input stream and match output stream
// slave side is the filter, master side is the producer/consumer
interface sha_match_filter_if #(
  parameter int IDX_W = 64
) ();
  logic             hash_vld;
  logic             hash_rdy;
  logic [255:0]     hash;
  logic             match_vld;
  logic             match_rdy;
  logic [IDX_W-1:0] match_idx;
  logic [255:0]     match_hash;

  modport slave (
    input  hash_vld, hash, match_rdy,
    output hash_rdy, match_vld, match_idx, match_hash
  );

  modport master (
    output hash_vld, hash, match_rdy,
    input  hash_rdy, match_vld, match_idx, match_hash
  );
endinterface

// File: rtl/sha_match_filter.sv
// sha_match_filter: masked digest compare with an indexed match FIFO
// two-stage compare pipeline; a FIFO slot is reserved at every accept
module sha_match_filter #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 64,
  parameter int MCNT_W     = 32
) (
  input  logic               clk_axi,
  input  logic               rst,
  input  logic               cfg_vld,
  input  logic [255:0]       cfg_target,
  input  logic [255:0]       cfg_mask,
  sha_match_filter_if.slave  hs,
  output logic [IDX_W-1:0]   hash_cnt,
  output logic [MCNT_W-1:0]  match_cnt,
  output logic               busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef logic [AW-1:0] ptr_t;

  logic [255:0]     target_q;
  logic [255:0]     mask_q;
  logic [7:0]       eq;
  logic             s1_vld;
  logic [7:0]       s1_eq;
  logic [255:0]     s1_hash;
  logic [IDX_W-1:0] s1_idx;
  logic             s2_vld;
  logic             s2_hit;
  logic [255:0]     s2_hash;
  logic [IDX_W-1:0] s2_idx;
  logic [IDX_W-1:0] mem_idx [FIFO_DEPTH];
  logic [255:0]     mem_hash [FIFO_DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    pending;
  logic [IDX_W-1:0] last_idx;
  logic [255:0]     last_hash;
  logic             accept;
  logic             push;
  logic             pop;

  always_comb begin
    eq = '0;
    for (int k = 0; k < 8; k++)
      eq[k] = ((hs.hash[32*k +: 32] ^ target_q[32*k +: 32])
              & mask_q[32*k +: 32]) == 32'd0;
  end

  // in-flight digests count against the FIFO so a match never finds it full
  assign pending     = count + CW'(s1_vld) + CW'(s2_vld);
  assign hs.hash_rdy = !rst && !cfg_vld && (pending < CW'(FIFO_DEPTH));

  assign accept = hs.hash_vld & hs.hash_rdy;
  assign push   = s2_vld & s2_hit;

  assign hs.match_vld  = count != '0;
  assign pop           = hs.match_vld & hs.match_rdy;
  assign hs.match_idx  = hs.match_vld ? mem_idx[rd_ptr]  : last_idx;
  assign hs.match_hash = hs.match_vld ? mem_hash[rd_ptr] : last_hash;

  assign busy = s1_vld | s2_vld | hs.match_vld;

  always_ff @(posedge clk_axi) begin
    if (push && !cfg_vld) begin
      mem_idx[wr_ptr]  <= s2_idx;
      mem_hash[wr_ptr] <= s2_hash;
    end
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      target_q  <= '0;
      mask_q    <= '0;
      hash_cnt  <= '0;
      match_cnt <= '0;
      s1_vld    <= 1'b0;
      s1_eq     <= '0;
      s1_hash   <= '0;
      s1_idx    <= '0;
      s2_vld    <= 1'b0;
      s2_hit    <= 1'b0;
      s2_hash   <= '0;
      s2_idx    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_idx  <= '0;
      last_hash <= '0;
    end else if (cfg_vld) begin
      target_q  <= cfg_target;
      mask_q    <= cfg_mask;
      hash_cnt  <= '0;
      match_cnt <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_idx  <= hs.match_idx;
      last_hash <= hs.match_hash;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_eq    <= eq;
        s1_hash  <= hs.hash;
        s1_idx   <= hash_cnt;
        hash_cnt <= hash_cnt + IDX_W'(1);
      end
      s2_vld  <= s1_vld;
      s2_hit  <= &s1_eq;
      s2_hash <= s1_hash;
      s2_idx  <= s1_idx;
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
        if (match_cnt != '1)
          match_cnt <= match_cnt + MCNT_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + ptr_t'(1);
      count     <= count + CW'(push) - CW'(pop);
      last_idx  <= hs.match_idx;
      last_hash <= hs.match_hash;
    end
  end
endmodule

// File: tb/tb_sha_match_filter.sv
// tb_sha_match_filter: vector table plus directed handshake sequences
// a narrow second instance covers index wrap and counter saturation
module tb_sha_match_filter;
  logic         clk_axi = 1'b0;
  logic         rst;
  logic         cfg_vld;
  logic [255:0] cfg_target;
  logic [255:0] cfg_mask;
  logic [63:0]  hash_cnt;
  logic [31:0]  match_cnt;
  logic         busy;
  logic [2:0]   s_hash_cnt;
  logic [1:0]   s_match_cnt;
  logic         s_busy;
  int           nerr = 0;
  int           nchk = 0;

  always #5 clk_axi = ~clk_axi;

  sha_match_filter_if #(.IDX_W(64)) mif ();
  sha_match_filter_if #(.IDX_W(3))  sif ();

  assign sif.hash_vld  = mif.hash_vld;
  assign sif.hash      = mif.hash;
  assign sif.match_rdy = mif.match_rdy;

  sha_match_filter #(.FIFO_DEPTH(4), .IDX_W(64), .MCNT_W(32)) dut (
    .clk_axi(clk_axi), .rst(rst), .cfg_vld(cfg_vld),
    .cfg_target(cfg_target), .cfg_mask(cfg_mask), .hs(mif),
    .hash_cnt(hash_cnt), .match_cnt(match_cnt), .busy(busy)
  );

  sha_match_filter #(.FIFO_DEPTH(4), .IDX_W(3), .MCNT_W(2)) dut_s (
    .clk_axi(clk_axi), .rst(rst), .cfg_vld(cfg_vld),
    .cfg_target(cfg_target), .cfg_mask(cfg_mask), .hs(sif),
    .hash_cnt(s_hash_cnt), .match_cnt(s_match_cnt), .busy(s_busy)
  );

  typedef struct {
    logic         c;
    logic [255:0] t;
    logic [255:0] m;
    logic         hv;
    logic [255:0] h;
    logic         mr;
    logic         e_rdy;
    logic         e_mv;
    logic [63:0]  e_idx;
    logic [255:0] e_mh;
    logic [63:0]  e_hc;
    logic [31:0]  e_mc;
    logic         e_b;
  } vec_t;

  vec_t         tv[$];
  logic [255:0] acc_q[$];
  logic [63:0]  pop_idx[$];
  logic [255:0] pop_hash[$];
  logic [2:0]   spop_idx[$];
  logic [255:0] spop_hash[$];

  function automatic logic [255:0] h1(int i);
    return {8{32'hA5A5_0000 + 32'(i)}};
  endfunction

  function automatic logic [255:0] d2(int i);
    logic [7:0] b;
    b = 8'(i) + 8'h11;
    return {(i == 3 || i == 7) ? 8'hFF : 8'h00, {31{b}}};
  endfunction

  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic add(
    input logic c, input logic [255:0] t, input logic [255:0] m,
    input logic hv, input logic [255:0] h, input logic mr,
    input logic r, input logic mv, input logic [63:0] idx,
    input logic [255:0] mh, input logic [63:0] hc,
    input logic [31:0] mc, input logic b
  );
    tv.push_back('{c, t, m, hv, h, mr, r, mv, idx, mh, hc, mc, b});
  endtask

  task automatic clr_q();
    acc_q.delete();
    pop_idx.delete();
    pop_hash.delete();
    spop_idx.delete();
    spop_hash.delete();
  endtask

  task automatic step();
    logic         acc, pop, spop;
    logic [63:0]  pi;
    logic [2:0]   si;
    logic [255:0] hin, ph, sh;
    #1;
    acc  = mif.hash_vld & mif.hash_rdy;
    hin  = mif.hash;
    pop  = mif.match_vld & mif.match_rdy;
    pi   = mif.match_idx;
    ph   = mif.match_hash;
    spop = sif.match_vld & sif.match_rdy;
    si   = sif.match_idx;
    sh   = sif.match_hash;
    @(posedge clk_axi);
    #1;
    if (acc) acc_q.push_back(hin);
    if (pop) begin
      pop_idx.push_back(pi);
      pop_hash.push_back(ph);
    end
    if (spop) begin
      spop_idx.push_back(si);
      spop_hash.push_back(sh);
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, " rdy"},   mif.hash_rdy,   0);
    chk({n, " mv"},    mif.match_vld,  0);
    chk({n, " idx"},   mif.match_idx,  0);
    chk({n, " mh"},    mif.match_hash, 0);
    chk({n, " hc"},    hash_cnt,       0);
    chk({n, " mc"},    match_cnt,      0);
    chk({n, " busy"},  busy,           0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    cfg_vld       = 1'b0;
    cfg_target    = '0;
    cfg_mask      = '0;
    mif.hash_vld  = 1'b0;
    mif.hash      = '0;
    mif.match_rdy = 1'b0;
    #1;
    chk_zero("reset");
    @(posedge clk_axi);
    #1;
    rst = 1'b0;
    clr_q();
  endtask

  task automatic do_cfg(logic [255:0] t, logic [255:0] m);
    cfg_vld    = 1'b1;
    cfg_target = t;
    cfg_mask   = m;
    step();
    cfg_vld = 1'b0;
  endtask

  task automatic run_tv(string n);
    foreach (tv[i]) begin
      cfg_vld       = tv[i].c;
      cfg_target    = tv[i].t;
      cfg_mask      = tv[i].m;
      mif.hash_vld  = tv[i].hv;
      mif.hash      = tv[i].h;
      mif.match_rdy = tv[i].mr;
      #1;
      chk($sformatf("%s v%0d rdy", n, i), mif.hash_rdy, tv[i].e_rdy);
      @(posedge clk_axi);
      #1;
      chk($sformatf("%s v%0d mv", n, i),   mif.match_vld,  tv[i].e_mv);
      chk($sformatf("%s v%0d idx", n, i),  mif.match_idx,  tv[i].e_idx);
      chk($sformatf("%s v%0d mh", n, i),   mif.match_hash, tv[i].e_mh);
      chk($sformatf("%s v%0d hc", n, i),   hash_cnt,       tv[i].e_hc);
      chk($sformatf("%s v%0d mc", n, i),   match_cnt,      tv[i].e_mc);
      chk($sformatf("%s v%0d busy", n, i), busy,           tv[i].e_b);
    end
    cfg_vld      = 1'b0;
    mif.hash_vld = 1'b0;
    tv.delete();
  endtask

  initial begin
    logic [255:0] tg, mk;
    tg = '1;
    mk = {8'hFF, 248'h0};

    // all-match stream with the consumer always ready
    do_reset();
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, h1(0), 1, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, h1(1), 1, 1, 0, 0, 0, 2, 0, 1);
    for (int k = 3; k <= 10; k++)
      add(0, 0, 0, 1, h1(k-1), 1, 1, 1, k-3, h1(k-3), k, k-2, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 8, h1(8), 10, 9, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 9, h1(9), 10, 10, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 9, h1(9), 10, 10, 0);
    run_tv("allmatch");

    // masked compare on the top byte only
    do_reset();
    add(1, tg, mk, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k <= 5)
        add(0, 0, 0, 1, d2(k-1), 1, 1, 0, 0, 0, k, 0, 1);
      else if (k == 6)
        add(0, 0, 0, 1, d2(k-1), 1, 1, 1, 3, d2(3), k, 1, 1);
      else if (k <= 9)
        add(0, 0, 0, 1, d2(k-1), 1, 1, 0, 3, d2(3), k, 1, 1);
      else
        add(0, 0, 0, 1, d2(k-1), 1, 1, 1, 7, d2(7), k, 2, 1);
    end
    add(0, 0, 0, 0, 0, 1, 1, 0, 7, d2(7), 10, 2, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 7, d2(7), 10, 2, 0);
    run_tv("masked");

    // backpressure: consumer stalled, then released
    do_reset();
    do_cfg('0, '0);
    mif.match_rdy = 1'b0;
    mif.hash_vld  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      mif.hash = h1(acc_q.size());
      step();
    end
    chk("bp accepts", acc_q.size(), 4);
    chk("bp rdy low", mif.hash_rdy, 0);
    chk("bp hc", hash_cnt, 4);
    chk("bp mc", match_cnt, 4);
    chk("bp head", mif.match_idx, 0);
    mif.match_rdy = 1'b1;
    #1;
    chk("bp rdy at pop", mif.hash_rdy, 0);
    step();
    chk("bp rdy resume", mif.hash_rdy, 1);
    for (int j = 0; j < 6; j++) begin
      mif.hash = h1(acc_q.size());
      step();
    end
    mif.hash_vld = 1'b0;
    for (int j = 0; j < 8; j++) step();
    chk("bp pop count", pop_idx.size(), acc_q.size());
    chk("bp hc final", hash_cnt, acc_q.size());
    foreach (pop_idx[i]) begin
      chk($sformatf("bp pop%0d idx", i), pop_idx[i], i);
      chk($sformatf("bp pop%0d hash", i), pop_hash[i], acc_q[i]);
    end

    // cfg pulse with FIFO and both stages occupied
    do_reset();
    do_cfg('0, '0);
    mif.match_rdy = 1'b0;
    mif.hash_vld  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      mif.hash = h1(100 + j);
      step();
    end
    chk("cfg pre accepts", acc_q.size(), 4);
    chk("cfg pre mv", mif.match_vld, 1);
    cfg_vld = 1'b1;
    #1;
    chk("cfg rdy", mif.hash_rdy, 0);
    step();
    cfg_vld = 1'b0;
    chk("cfg no accept", acc_q.size(), 4);
    chk("cfg mv", mif.match_vld, 0);
    chk("cfg hc", hash_cnt, 0);
    chk("cfg mc", match_cnt, 0);
    chk("cfg busy", busy, 0);
    clr_q();
    mif.match_rdy = 1'b1;
    mif.hash      = h1(500);
    step();
    mif.hash_vld = 1'b0;
    for (int j = 0; j < 6; j++) step();
    chk("cfg post pops", pop_idx.size(), 1);
    if (pop_idx.size() > 0) begin
      chk("cfg post idx", pop_idx[0], 0);
      chk("cfg post hash", pop_hash[0], h1(500));
    end

    // asynchronous reset between clock edges
    do_reset();
    do_cfg('0, '0);
    mif.match_rdy = 1'b1;
    mif.hash_vld  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      mif.hash = h1(j);
      step();
    end
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async");
    @(posedge clk_axi);
    #1;
    rst          = 1'b0;
    mif.hash_vld = 1'b0;
    do_cfg('0, '0);
    clr_q();
    mif.hash_vld = 1'b1;
    for (int j = 0; j < 3; j++) begin
      mif.hash = h1(300 + j);
      step();
    end
    mif.hash_vld = 1'b0;
    for (int j = 0; j < 6; j++) step();
    chk("async pops", pop_idx.size(), 3);
    foreach (pop_idx[i]) begin
      chk($sformatf("async pop%0d idx", i), pop_idx[i], i);
      chk($sformatf("async pop%0d hash", i), pop_hash[i], h1(300 + i));
    end

    // narrow instance: index wrap and saturating match count
    do_reset();
    do_cfg('0, '0);
    mif.match_rdy = 1'b1;
    mif.hash_vld  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      mif.hash = h1(j);
      step();
    end
    mif.hash_vld = 1'b0;
    for (int j = 0; j < 6; j++) step();
    chk("wrap pops", spop_idx.size(), 10);
    foreach (spop_idx[i]) begin
      chk($sformatf("wrap pop%0d idx", i), spop_idx[i], i % 8);
      chk($sformatf("wrap pop%0d hash", i), spop_hash[i], h1(i));
    end
    chk("wrap hc", s_hash_cnt, 2);
    chk("sat mc", s_match_cnt, 3);
    chk("sat busy", s_busy, 0);
    chk("wide mc", match_cnt, 10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
